// File: rtl/ram256x1_byte_ctrl.sv
// Byte-wide request/response front end for a 256x1 single-bit RAM.
// Each accepted request is serialised into eight single-bit RAM accesses:
// writes are posted, and reads are assembled into a byte and returned
// through a valid/ready response port. Bit order within a byte is selected
// by MSB_FIRST.
module ram256x1_byte_ctrl #(
    parameter logic MSB_FIRST = 1'b0
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic       REQ_WE,
    input  logic [4:0] REQ_ADDR,
    input  logic [7:0] REQ_WDATA,
    output logic       RSP_VALID,
    input  logic       RSP_READY,
    output logic [7:0] RSP_RDATA,
    output logic       RAM_WE,
    output logic [7:0] RAM_A,
    output logic       RAM_D,
    input  logic       RAM_O
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t     state_reg, state_next;
    logic [2:0] cnt_reg, cnt_next;
    logic [4:0] addr_reg, addr_next;
    logic [7:0] wdata_reg, wdata_next;
    logic [7:0] rdata_reg, rdata_next;
    logic [2:0] bit_idx;
    logic [2:0] bit_next;

    // Output registers; they are loaded from the next-state values so that
    // they always agree with the state and counter they describe.
    logic       ram_we_reg;
    logic       ram_d_reg;
    logic [7:0] ram_a_reg;
    logic       req_ready_reg;
    logic       rsp_valid_reg;

    // Bit of the byte addressed by the current counter value.
    assign bit_idx = MSB_FIRST ? (3'd7 - cnt_reg) : cnt_reg;

    // Next-state logic: request acceptance, bit sequencing and read capture.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        rdata_next = rdata_reg;
        bit_next   = 3'd0;

        case (state_reg)
            IDLE: begin
                if (REQ_VALID) begin
                    addr_next  = REQ_ADDR;
                    wdata_next = REQ_WDATA;
                    cnt_next   = 3'd0;
                    state_next = REQ_WE ? WRITE : READ;
                end
            end
            WRITE: begin
                // The counter wraps 7->0 on the same edge the byte completes.
                cnt_next = cnt_reg + 3'd1;
                if (cnt_reg == 3'd7) begin
                    state_next = IDLE;
                end
            end
            READ: begin
                // RAM_O is combinational from RAM_A, which already points at
                // bit_idx during this cycle.
                rdata_next[bit_idx] = RAM_O;
                cnt_next            = cnt_reg + 3'd1;
                if (cnt_reg == 3'd7) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                // No new request is taken on the handshake edge itself.
                if (RSP_READY) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        bit_next = MSB_FIRST ? (3'd7 - cnt_next) : cnt_next;
    end

    // FSM state, data latches and registered RAM / handshake outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg     <= IDLE;
            cnt_reg       <= 3'd0;
            addr_reg      <= 5'd0;
            wdata_reg     <= 8'd0;
            rdata_reg     <= 8'd0;
            ram_we_reg    <= 1'b0;
            ram_d_reg     <= 1'b0;
            ram_a_reg     <= 8'd0;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            rdata_reg     <= rdata_next;
            ram_a_reg     <= {addr_next, bit_next};
            ram_we_reg    <= (state_next == WRITE);
            ram_d_reg     <= (state_next == WRITE) ? wdata_next[bit_next] : 1'b0;
            req_ready_reg <= (state_next == IDLE);
            rsp_valid_reg <= (state_next == RESP);
        end
    end

    assign REQ_READY = req_ready_reg;
    assign RSP_VALID = rsp_valid_reg;
    assign RSP_RDATA = rdata_reg;
    assign RAM_WE    = ram_we_reg;
    assign RAM_A     = ram_a_reg;
    assign RAM_D     = ram_d_reg;

endmodule

// File: tb/tb_ram256x1_byte_ctrl.sv
// Bench for ram256x1_byte_ctrl. Two instances (LSB-first and MSB-first) see
// the same request stream, each attached to its own 256x1 RAM model. A
// byte-level memory image predicts read data and RAM contents.
module tb_ram256x1_byte_ctrl;

    logic       CLK       = 1'b0;
    logic       RST_N     = 1'b0;
    logic       REQ_VALID = 1'b0;
    logic       REQ_WE    = 1'b0;
    logic [4:0] REQ_ADDR  = 5'd0;
    logic [7:0] REQ_WDATA = 8'd0;
    logic       RSP_READY = 1'b0;

    logic       req_ready [2];
    logic       rsp_valid [2];
    logic [7:0] rsp_rdata [2];
    logic       ram_we    [2];
    logic [7:0] ram_a     [2];
    logic       ram_d     [2];
    logic       ram_o     [2];

    logic [255:0] mem [2];
    logic         clear_mem = 1'b1;

    // Byte-level image of what each RAM should hold.
    logic [7:0] model [2][32];

    int n_checks = 0;
    int n_pass   = 0;

    // Request to present on the first cycle of the current operation.
    logic       nxt_valid = 1'b0;
    logic       nxt_we    = 1'b0;
    logic [4:0] nxt_addr  = 5'd0;
    logic [7:0] nxt_data  = 8'd0;

    always #5 CLK = ~CLK;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            ram256x1_byte_ctrl #(
                .MSB_FIRST(gi == 1 ? 1'b1 : 1'b0)
            ) dut (
                .CLK      (CLK),
                .RST_N    (RST_N),
                .REQ_VALID(REQ_VALID),
                .REQ_READY(req_ready[gi]),
                .REQ_WE   (REQ_WE),
                .REQ_ADDR (REQ_ADDR),
                .REQ_WDATA(REQ_WDATA),
                .RSP_VALID(rsp_valid[gi]),
                .RSP_READY(RSP_READY),
                .RSP_RDATA(rsp_rdata[gi]),
                .RAM_WE   (ram_we[gi]),
                .RAM_A    (ram_a[gi]),
                .RAM_D    (ram_d[gi]),
                .RAM_O    (ram_o[gi])
            );
        end
    endgenerate

    // 256x1 RAMs: asynchronous read, write on rising edge.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            ram_o[i] = mem[i][ram_a[i]];
        end
    end

    always @(posedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (clear_mem) begin
                mem[i] <= '0;
            end else if (ram_we[i]) begin
                mem[i][ram_a[i]] <= ram_d[i];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bit of the byte handled in the k-th access of an operation.
    function automatic logic [2:0] seq_bit(input int inst, input int k);
        return (inst == 1) ? 3'(7 - k) : 3'(k);
    endfunction

    function automatic logic [7:0] ram_byte(input int inst, input logic [4:0] addr);
        return mem[inst][{addr, 3'b000} +: 8];
    endfunction

    task automatic apply_next();
        REQ_VALID = nxt_valid;
        if (nxt_valid) begin
            REQ_WE    = nxt_we;
            REQ_ADDR  = nxt_addr;
            REQ_WDATA = nxt_data;
        end
    endtask

    // Entered at a falling edge; returns just after the accepting rising edge.
    task automatic start_req(input logic we, input logic [4:0] addr, input logic [7:0] data);
        int waited = 0;
        while (req_ready[0] !== 1'b1 && waited < 40) begin
            @(negedge CLK);
            waited++;
        end
        check("idle_reached", 32'(req_ready[0]), 32'd1);
        REQ_VALID = 1'b1;
        REQ_WE    = we;
        REQ_ADDR  = addr;
        REQ_WDATA = data;
        @(posedge CLK);
    endtask

    task automatic write_body(input logic [4:0] addr, input logic [7:0] data);
        logic [2:0] b;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            if (k == 0) apply_next();
            for (int i = 0; i < 2; i++) begin
                b = seq_bit(i, k);
                check("wr_we",   32'(ram_we[i]),    32'd1);
                check("wr_addr", 32'(ram_a[i]),     32'({addr, b}));
                check("wr_d",    32'(ram_d[i]),     32'(data[b]));
                check("wr_busy", 32'(req_ready[i]), 32'd0);
            end
        end
        @(negedge CLK);
        for (int i = 0; i < 2; i++) begin
            model[i][addr] = data;
            check("wr_done_ready", 32'(req_ready[i]), 32'd1);
            check("wr_done_we",    32'(ram_we[i]),    32'd0);
            check("wr_done_d",     32'(ram_d[i]),     32'd0);
            check("wr_no_rsp",     32'(rsp_valid[i]), 32'd0);
            check("wr_ram",        32'(ram_byte(i, addr)), 32'(model[i][addr]));
        end
    endtask

    task automatic read_body(input logic [4:0] addr, input int stall);
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            if (k == 0) apply_next();
            for (int i = 0; i < 2; i++) begin
                check("rd_addr",  32'(ram_a[i]),     32'({addr, seq_bit(i, k)}));
                check("rd_we",    32'(ram_we[i]),    32'd0);
                check("rd_early", 32'(rsp_valid[i]), 32'd0);
                check("rd_busy",  32'(req_ready[i]), 32'd0);
            end
        end
        @(negedge CLK);
        for (int i = 0; i < 2; i++) begin
            check("rd_latency", 32'(rsp_valid[i]), 32'd1);
            check("rd_data",    32'(rsp_rdata[i]), 32'(model[i][addr]));
        end
        for (int s = 0; s < stall; s++) begin
            @(posedge CLK);
            @(negedge CLK);
            for (int i = 0; i < 2; i++) begin
                check("stall_valid", 32'(rsp_valid[i]), 32'd1);
                check("stall_data",  32'(rsp_rdata[i]), 32'(model[i][addr]));
                check("stall_busy",  32'(req_ready[i]), 32'd0);
            end
        end
        RSP_READY = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RSP_READY = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("rsp_done_valid", 32'(rsp_valid[i]), 32'd0);
            check("rsp_done_ready", 32'(req_ready[i]), 32'd1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            check({tag, "_ready"}, 32'(req_ready[i]), 32'd1);
            check({tag, "_valid"}, 32'(rsp_valid[i]), 32'd0);
            check({tag, "_rdata"}, 32'(rsp_rdata[i]), 32'd0);
            check({tag, "_we"},    32'(ram_we[i]),    32'd0);
            check({tag, "_d"},     32'(ram_d[i]),     32'd0);
            check({tag, "_a"},     32'(ram_a[i]),     32'd0);
        end
    endtask

    task automatic do_write(input logic [4:0] addr, input logic [7:0] data);
        start_req(1'b1, addr, data);
        write_body(addr, data);
        $display("txn write addr=%0d data=%02h", addr, data);
    endtask

    task automatic do_read(input logic [4:0] addr, input int stall);
        start_req(1'b0, addr, 8'h00);
        read_body(addr, stall);
        $display("txn read  addr=%0d stall=%0d expect=%02h/%02h", addr, stall,
                 model[0][addr], model[1][addr]);
    endtask

    initial begin
        int waits [2] = '{4, 9};
        logic       cur_we;
        logic [4:0] cur_addr;
        logic [7:0] cur_data;
        logic       back;
        int         stall;

        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 32; a++)
                model[i][a] = 8'h00;

        // Reset state, with the RAMs cleared underneath.
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        clear_mem = 1'b0;
        RST_N     = 1'b1;

        // Directed byte write/read, both bit orders.
        do_write(5'd5, 8'hA5);
        check("ram_bits_40_47", 32'(mem[0][47:40]), 32'h0000_00A5);
        do_read(5'd5, 0);
        do_write(5'd31, 8'h01);
        check("msb_ram_248", 32'(mem[1][255:248]), 32'h0000_0001);
        do_read(5'd31, 0);
        do_read(5'd5, 5);

        // Held REQ_VALID: write then read of the same byte, back to back.
        nxt_valid = 1'b1; nxt_we = 1'b0; nxt_addr = 5'd12; nxt_data = 8'h00;
        start_req(1'b1, 5'd12, 8'h3C);
        write_body(5'd12, 8'h3C);
        $display("txn write addr=12 data=3c (read held behind it)");
        nxt_valid = 1'b0;
        start_req(1'b0, 5'd12, 8'h00);
        read_body(5'd12, 0);
        $display("txn read  addr=12 stall=0 expect=%02h/%02h", model[0][12], model[1][12]);

        // Reset after three write cycles of 8'hFF to byte 0 over a cleared RAM.
        clear_mem = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        clear_mem = 1'b0;
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 32; a++)
                model[i][a] = 8'h00;
        start_req(1'b1, 5'd0, 8'hFF);
        @(negedge CLK);
        REQ_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        for (int i = 0; i < 2; i++) check("pre_reset_we", 32'(ram_we[i]), 32'd1);
        RST_N = 1'b0;
        #1;
        check_reset_outputs("wr_reset");
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 3; k++) model[i][0][seq_bit(i, k)] = 1'b1;
            check("wr_reset_ram", 32'(ram_byte(i, 5'd0)), 32'(model[i][0]));
        end
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);
        for (int i = 0; i < 2; i++)
            check("post_reset_ram", 32'(ram_byte(i, 5'd0)), 32'(model[i][0]));
        $display("txn write addr=0 data=ff interrupted by reset");

        // Reset while a read is in flight and while its response is pending.
        for (int j = 0; j < 2; j++) begin
            start_req(1'b0, 5'd0, 8'h00);
            for (int k = 0; k < waits[j]; k++) begin
                @(negedge CLK);
                if (k == 0) REQ_VALID = 1'b0;
            end
            check("pre_reset_valid", 32'(rsp_valid[0]), (j == 1) ? 32'd1 : 32'd0);
            RST_N = 1'b0;
            #1;
            check_reset_outputs("rd_reset");
            @(negedge CLK);
            RST_N = 1'b1;
            for (int c = 0; c < 12; c++) begin
                @(negedge CLK);
                for (int i = 0; i < 2; i++) check("no_stale_rsp", 32'(rsp_valid[i]), 32'd0);
            end
            $display("txn read  addr=0 interrupted by reset after %0d cycles", waits[j]);
        end

        // Random traffic, with occasional back-to-back held requests.
        back     = 1'b0;
        cur_we   = 1'b0;
        cur_addr = 5'd0;
        cur_data = 8'd0;
        for (int t = 0; t < 60; t++) begin
            if (!back) begin
                cur_we   = 1'($urandom_range(0, 1));
                cur_addr = 5'($urandom_range(0, 31));
                cur_data = 8'($urandom_range(0, 255));
            end
            stall     = $urandom_range(0, 3);
            back      = (t != 59) && ($urandom_range(0, 2) == 0);
            nxt_valid = back;
            nxt_we    = 1'($urandom_range(0, 1));
            nxt_addr  = ($urandom_range(0, 1) == 0) ? cur_addr : 5'($urandom_range(0, 31));
            nxt_data  = 8'($urandom_range(0, 255));
            start_req(cur_we, cur_addr, cur_data);
            if (cur_we) begin
                write_body(cur_addr, cur_data);
                $display("txn %0d write addr=%0d data=%02h held_next=%0d", t, cur_addr, cur_data, back);
            end else begin
                read_body(cur_addr, stall);
                $display("txn %0d read  addr=%0d stall=%0d expect=%02h/%02h held_next=%0d",
                         t, cur_addr, stall, model[0][cur_addr], model[1][cur_addr], back);
            end
            if (back) begin
                cur_we   = nxt_we;
                cur_addr = nxt_addr;
                cur_data = nxt_data;
            end
            nxt_valid = 1'b0;
        end

        // Final sweep: whole RAM image against the byte model.
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 32; a++)
                check("final_ram", 32'(ram_byte(i, 5'(a))), 32'(model[i][a]));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
